// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - cycle-accurate responder for a 16-bit external SRAM bus
// Optional bus protocol checker enabled by defining SRAM_PROTO_CHECK_EN.
module sram_responder #(
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 1024,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  input  logic [ADDR_W-1:0] SRAM_ADDR,
  input  logic              SRAM_UB_N,
  input  logic              SRAM_LB_N,
  input  logic              SRAM_WE_N,
  input  logic              SRAM_CE_N,
  input  logic              SRAM_OE_N,
  output logic              rd_valid,
  output logic              wr_done,
  output logic [15:0]       access_cnt,
  output logic              protocol_err
);

  localparam int LANE_W  = DATA_W / 2;
  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_DRIVE = 2'd3;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_dq;
  logic              lat_ub_n;
  logic              lat_lb_n;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;

  logic wr_req;
  logic rd_req;
  logic hold_read;
  logic last_edge;
  logic drive_ok;

  assign wr_req    = !SRAM_CE_N && !SRAM_WE_N;
  assign rd_req    = !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;
  assign hold_read = (state == S_DRIVE) && rd_req && (SRAM_ADDR == lat_addr);
  assign last_edge = ((state == S_WRITE) || (state == S_READ)) && (cnt == CNT_W'(1));
  assign idx       = IDX_W'(lat_addr % ADDR_W'(DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      lat_addr   <= '0;
      lat_dq     <= '0;
      lat_ub_n   <= 1'b1;
      lat_lb_n   <= 1'b1;
      wr_done    <= 1'b0;
      access_cnt <= '0;
    end else begin
      wr_done <= 1'b0;
      case (state)
        S_WRITE, S_READ: begin
          cnt <= cnt - CNT_W'(1);
          if (last_edge) begin
            access_cnt <= access_cnt + 16'd1;
            wr_done    <= (state == S_WRITE);
            state      <= (state == S_WRITE) ? S_IDLE : S_DRIVE;
          end
        end
        default: begin
          // A read held on the same address keeps driving without a new launch
          if (!hold_read) begin
            if (wr_req) begin
              state    <= S_WRITE;
              cnt      <= CNT_W'(WRITE_LAT);
              lat_addr <= SRAM_ADDR;
              lat_dq   <= SRAM_DQ;
              lat_ub_n <= SRAM_UB_N;
              lat_lb_n <= SRAM_LB_N;
            end else if (rd_req) begin
              state    <= S_READ;
              cnt      <= CNT_W'(READ_LAT);
              lat_addr <= SRAM_ADDR;
              lat_ub_n <= SRAM_UB_N;
              lat_lb_n <= SRAM_LB_N;
            end else begin
              state <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

  // Storage is never reset; reset forces IDLE so no commit can occur while held
  always_ff @(posedge clk) begin
    if (last_edge && (state == S_WRITE)) begin
      if (!lat_ub_n) mem[idx][DATA_W-1:LANE_W] <= lat_dq[DATA_W-1:LANE_W];
      if (!lat_lb_n) mem[idx][LANE_W-1:0]      <= lat_dq[LANE_W-1:0];
    end
    if (last_edge && (state == S_READ)) begin
      rd_data <= mem[idx];
    end
  end

  assign rd_valid = (state == S_DRIVE);
  assign drive_ok = (state == S_DRIVE) && !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;

  assign SRAM_DQ[DATA_W-1:LANE_W] = (drive_ok && !SRAM_UB_N) ? rd_data[DATA_W-1:LANE_W]
                                                            : {LANE_W{1'bz}};
  assign SRAM_DQ[LANE_W-1:0]      = (drive_ok && !SRAM_LB_N) ? rd_data[LANE_W-1:0]
                                                            : {LANE_W{1'bz}};

`ifdef SRAM_PROTO_CHECK_EN
  logic busy;
  logic viol;

  assign busy = (state == S_WRITE) || (state == S_READ);
  // WE_N must stay at the level it had at capture: low for writes, high for reads
  assign viol = (!SRAM_CE_N && !SRAM_WE_N && !SRAM_OE_N) ||
                (busy && (SRAM_CE_N || (SRAM_ADDR != lat_addr) ||
                          (SRAM_WE_N != (state == S_READ))));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      protocol_err <= 1'b0;
    end else if (viol) begin
      protocol_err <= 1'b1;
    end
  end
`else
  assign protocol_err = 1'b0;
`endif

endmodule
